// File: rtl/matmul_pkg.sv
// Shared constants and types for the matrix-multiplier result drain.
package matmul_pkg;

    localparam int unsigned N          = 8;
    localparam int unsigned ELEM_IN_W  = 16;
    localparam int unsigned ELEM_OUT_W = 8;
    localparam int unsigned IDX_W      = $clog2(N);
    localparam int unsigned SAT_CNT_W  = $clog2(N * N + 1);

    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    typedef enum logic {
        IDLE,
        STREAM
    } drain_state_t;

endpackage

// File: rtl/matmul_result_drain_requant8.sv
// requant8: round, arithmetic shift and saturate a 16-bit element to signed 8-bit.
// Optional MATMUL_DRAIN_RELU_EN zeroes negative results after clamping.
module requant8
    import matmul_pkg::*;
#(
    parameter int unsigned SHIFT = 4
) (
    input  logic [ELEM_IN_W-1:0]  x,
    output logic [ELEM_OUT_W-1:0] y,
    output logic                  sat
);

    localparam logic signed [16:0] HI = 17'(SAT_MAX);
    localparam logic signed [16:0] LO = 17'(SAT_MIN);

    logic signed [16:0] xe;
    logic signed [16:0] t;

    assign xe = {x[ELEM_IN_W-1], x};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [16:0] RND = 17'(1 << (SHIFT - 1));
            // 17 bits absorb the rounding carry even at SHIFT=15
            assign t = (xe + RND) >>> SHIFT;
        end else begin : g_pass
            assign t = xe;
        end
    endgenerate

    always_comb begin
        y   = t[ELEM_OUT_W-1:0];
        sat = 1'b0;
        if (t > HI) begin
            y   = ELEM_OUT_W'(SAT_MAX);
            sat = 1'b1;
        end else if (t < LO) begin
            y   = ELEM_OUT_W'(SAT_MIN);
            sat = 1'b1;
        end
`ifdef MATMUL_DRAIN_RELU_EN
        if (y[ELEM_OUT_W-1]) begin
            y   = '0;
            sat = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/matmul_result_drain.sv
// Captures the multiplier result matrix on done_in rise and streams requantized
// elements row-major over valid/ready. ReLU variant via MATMUL_DRAIN_RELU_EN.
module matmul_result_drain
    import matmul_pkg::*;
#(
    parameter int unsigned SHIFT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       done_in,
    input  logic [N*N*ELEM_IN_W-1:0]   c_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ELEM_OUT_W-1:0]      out_data,
    output logic [IDX_W-1:0]           out_row,
    output logic [IDX_W-1:0]           out_col,
    output logic                       out_last,
    output logic                       busy,
    output logic                       matrix_done,
    output logic                       overrun,
    output logic [SAT_CNT_W-1:0]       sat_count
);

    drain_state_t state, state_nxt;

    logic                     done_q;
    logic [N*N*ELEM_IN_W-1:0] buf_q;
    logic [IDX_W-1:0]         row_q, col_q, nrow, ncol;
    logic [ELEM_OUT_W-1:0]    data_q;
    logic                     sat_cur_q;
    logic                     last_q;
    logic                     md_q, ovr_q;
    logic [SAT_CNT_W-1:0]     sat_cnt_q;

    logic                     rise, capture, xfer, at_last;
    int unsigned              nidx;
    logic [ELEM_IN_W-1:0]     rq_x;
    logic [ELEM_OUT_W-1:0]    rq_y;
    logic                     rq_sat;

    assign rise    = done_in & ~done_q;
    assign capture = (state == IDLE) & rise;
    assign xfer    = (state == STREAM) & out_ready;
    assign at_last = (row_q == IDX_W'(N - 1)) && (col_q == IDX_W'(N - 1));

    always_comb begin
        nrow = row_q;
        ncol = col_q + IDX_W'(1);
        if (col_q == IDX_W'(N - 1)) begin
            ncol = '0;
            nrow = row_q + IDX_W'(1);
        end
        nidx = 32'(nrow) * N + 32'(ncol);
        // Output registers are loaded one element ahead: from c_in itself on
        // capture (buffer not yet written), otherwise from the next buffer slot.
        rq_x = capture ? c_in[ELEM_IN_W-1:0] : buf_q[nidx*ELEM_IN_W +: ELEM_IN_W];
    end

    requant8 #(.SHIFT(SHIFT)) u_requant (
        .x   (rq_x),
        .y   (rq_y),
        .sat (rq_sat)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = STREAM;
            STREAM:  if (xfer && at_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            data_q    <= '0;
            sat_cur_q <= 1'b0;
            last_q    <= 1'b0;
            md_q      <= 1'b0;
            ovr_q     <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= done_in;
            md_q   <= xfer & at_last;
            ovr_q  <= rise & (state == STREAM);
            if (capture) begin
                row_q     <= '0;
                col_q     <= '0;
                data_q    <= rq_y;
                sat_cur_q <= rq_sat;
                last_q    <= (N == 1);
                sat_cnt_q <= '0;
            end else if (xfer) begin
                row_q     <= nrow;
                col_q     <= ncol;
                data_q    <= rq_y;
                sat_cur_q <= rq_sat;
                last_q    <= (nrow == IDX_W'(N - 1)) && (ncol == IDX_W'(N - 1));
                sat_cnt_q <= sat_cnt_q + SAT_CNT_W'(sat_cur_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) buf_q <= c_in;
    end

    assign out_valid   = (state == STREAM);
    assign busy        = (state == STREAM);
    assign out_data    = data_q;
    assign out_row     = row_q;
    assign out_col     = col_q;
    assign out_last    = last_q;
    assign matrix_done = md_q;
    assign overrun     = ovr_q;
    assign sat_count   = sat_cnt_q;

endmodule

// File: tb/tb_matmul_result_drain.sv
// Self-checking bench for matmul_result_drain: scoreboard of expected elements
// filled at capture, consumed as the DUT streams. Honors MATMUL_DRAIN_RELU_EN.
module tb_matmul_result_drain;
    import matmul_pkg::*;

    localparam int unsigned SHIFT = 4;
    localparam int unsigned CW    = N * N * ELEM_IN_W;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  done_in;
    logic [CW-1:0]         c_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [ELEM_OUT_W-1:0] out_data;
    logic [IDX_W-1:0]      out_row, out_col;
    logic                  out_last, busy, matrix_done, overrun;
    logic [SAT_CNT_W-1:0]  sat_count;

    matmul_result_drain #(.SHIFT(SHIFT)) dut (
        .clk         (clk),
        .rst         (rst),
        .done_in     (done_in),
        .c_in        (c_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_last    (out_last),
        .busy        (busy),
        .matrix_done (matrix_done),
        .overrun     (overrun),
        .sat_count   (sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       d;
        logic [IDX_W-1:0] r;
        logic [IDX_W-1:0] c;
        logic             l;
    } exp_t;

    exp_t sb[$];
    int   exp_sat;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: floor division after rounding offset, then clamp.
    function automatic logic [8:0] model(input logic [15:0] x);
        int v, d, q;
        logic s;
        logic [7:0] y;
        v = int'($signed(x));
        d = 1 << SHIFT;
        if (SHIFT > 0) v = v + d / 2;
        q = v / d;
        if (v < 0 && (v % d) != 0) q = q - 1;
        s = 1'b0;
        if (q > 127) begin q = 127; s = 1'b1; end
        else if (q < -128) begin q = -128; s = 1'b1; end
`ifdef MATMUL_DRAIN_RELU_EN
        if (q < 0) begin q = 0; s = 1'b0; end
`endif
        y = q[7:0];
        return {s, y};
    endfunction

    function automatic logic [CW-1:0] rand_mat();
        logic [CW-1:0] m;
        for (int i = 0; i < N * N; i++) begin
            if ($urandom_range(0, 1) == 1) m[i*16 +: 16] = 16'($urandom);
            else m[i*16 +: 16] = 16'(int'($urandom_range(0, 4095)) - 2048);
        end
        return m;
    endfunction

    // Drive a done_in rise carrying m and queue its expected stream.
    task automatic capture(input logic [CW-1:0] m, input bit hold);
        exp_t e;
        logic [8:0] res;
        exp_sat = 0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                res = model(m[(r*N+c)*16 +: 16]);
                e.d = res[7:0];
                e.r = IDX_W'(r);
                e.c = IDX_W'(c);
                e.l = (r == N - 1) && (c == N - 1);
                sb.push_back(e);
                exp_sat += int'(res[8]);
            end
        end
        c_in    = m;
        done_in = 1'b1;
        step();
        if (!hold) done_in = 1'b0;
    endtask

    // Scoreboard consumer: pops on each transfer, checks stall stability and
    // end-of-matrix status when the queue empties.
    task automatic drain(input int pct, input int max_xfer, output int ncyc);
        int nx = 0;
        bit stalled = 1'b0;
        logic [7:0] pd;
        logic [IDX_W-1:0] pr, pc;
        exp_t e;
        ncyc = 0;
        while (nx < max_xfer && sb.size() > 0 && ncyc < 2000) begin
            if (stalled) begin
                n_cmp++;
                if ({out_valid, out_data, out_row, out_col} !== {1'b1, pd, pr, pc}) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%0b d=%0d r=%0d c=%0d want v=1 d=%0d r=%0d c=%0d",
                             out_valid, $signed(out_data), out_row, out_col, $signed(pd), pr, pc);
                end
            end
            out_ready = ($urandom_range(0, 99) < pct);
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                n_cmp++;
                if ({out_data, out_row, out_col, out_last} !== {e.d, e.r, e.c, e.l}) begin
                    n_fail++;
                    $display("FAIL element: got d=%0d r=%0d c=%0d last=%0b want d=%0d r=%0d c=%0d last=%0b",
                             $signed(out_data), out_row, out_col, out_last,
                             $signed(e.d), e.r, e.c, e.l);
                end
                nx++;
            end
            stalled = out_valid && !out_ready;
            pd = out_data;
            pr = out_row;
            pc = out_col;
            step();
            ncyc++;
        end
        if (sb.size() > 0 && nx < max_xfer) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d elements left after %0d cycles want 0", sb.size(), ncyc);
            sb.delete();
        end else if (sb.size() == 0) begin
            n_cmp++;
            if ({matrix_done, busy, out_valid, sat_count} !== {1'b1, 1'b0, 1'b0, SAT_CNT_W'(exp_sat)}) begin
                n_fail++;
                $display("FAIL matrix_end: got done=%0b busy=%0b valid=%0b sat=%0d want 1 0 0 %0d",
                         matrix_done, busy, out_valid, sat_count, exp_sat);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if ({out_valid, out_data, out_row, out_col, out_last, busy, matrix_done, overrun, sat_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b d=%0d r=%0d c=%0d l=%0b b=%0b md=%0b ov=%0b sat=%0d want all 0",
                     out_valid, out_data, out_row, out_col, out_last, busy, matrix_done, overrun, sat_count);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [CW-1:0] m;
        int ncyc;
        for (int i = 0; i < N * N; i++) m[i*16 +: 16] = 16'd256;
        capture(m, 1'b0);
        drain(100, N * N, ncyc);
        n_cmp++;
        if (ncyc != N * N) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles want %0d", ncyc, N * N);
        end
    endtask

    task automatic test_saturation();
        logic [CW-1:0] m = '0;
        int ncyc;
        m[0*16 +: 16] = 16'sd32767;
        m[1*16 +: 16] = 16'h8000;
        m[2*16 +: 16] = -16'sd24;
        m[3*16 +: 16] = 16'sd7;
        m[4*16 +: 16] = 16'sd8;
        capture(m, 1'b0);
        sb[0].d = 8'd127;
`ifdef MATMUL_DRAIN_RELU_EN
        sb[1].d = 8'd0;
        sb[2].d = 8'd0;
        exp_sat = 1;
`else
        sb[1].d = 8'h80;
        sb[2].d = 8'hFF;
        exp_sat = 2;
`endif
        sb[3].d = 8'd0;
        sb[4].d = 8'd1;
        drain(100, N * N, ncyc);
    endtask

    task automatic test_stall();
        int ncyc;
        capture(rand_mat(), 1'b0);
        drain(50, N * N, ncyc);
    endtask

    task automatic test_overrun();
        int ncyc, novr = 0;
        out_ready = 1'b0;
        capture(rand_mat(), 1'b0);
        step();
        c_in    = rand_mat();
        done_in = 1'b1;
        step();
        done_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (overrun) novr++;
            step();
        end
        n_cmp++;
        if (novr != 1) begin
            n_fail++;
            $display("FAIL overrun_pulse: got %0d pulses want 1", novr);
        end
        drain(100, N * N, ncyc);
    endtask

    task automatic test_hold();
        int ncyc, nvalid = 0;
        capture(rand_mat(), 1'b1);
        drain(100, N * N, ncyc);
        for (int i = 0; i < 4; i++) begin
            if (out_valid || busy) nvalid++;
            step();
        end
        n_cmp++;
        if (nvalid != 0) begin
            n_fail++;
            $display("FAIL hold_single_capture: got %0d busy cycles want 0", nvalid);
        end
        done_in = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int ncyc;
        capture(rand_mat(), 1'b0);
        drain(100, N * N, ncyc);
        capture(rand_mat(), 1'b0);
        drain(70, N * N, ncyc);
    endtask

    task automatic test_rst_mid();
        int ncyc;
        capture(rand_mat(), 1'b0);
        drain(100, 20, ncyc);
        n_cmp++;
        if ({out_valid, out_row, out_col} !== {1'b1, 3'd2, 3'd4}) begin
            n_fail++;
            $display("FAIL mid_index: got v=%0b r=%0d c=%0d want 1 2 4", out_valid, out_row, out_col);
        end
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({out_valid, out_data, out_row, out_col, out_last, busy, matrix_done, overrun, sat_count} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%0b d=%0d r=%0d c=%0d l=%0b b=%0b md=%0b ov=%0b sat=%0d want all 0",
                     out_valid, out_data, out_row, out_col, out_last, busy, matrix_done, overrun, sat_count);
        end
        sb.delete();
        step();
        capture(rand_mat(), 1'b0);
        drain(100, N * N, ncyc);
    endtask

    initial begin
        rst       = 1'b1;
        done_in   = 1'b0;
        c_in      = '0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_saturation();
        test_stall();
        test_overrun();
        test_hold();
        test_back_to_back();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul_result_drain.md
# matmul_result_drain

Downstream stage of the sequential 8×8 signed matrix multiplier. On each completed product it captures the flattened 64×16-bit result matrix C, requantizes every element to signed 8-bit (round, arithmetic shift, saturate) and streams the elements in row-major order over a valid/ready interface. It decouples the multiplier from slower consumers such as the memory writer and the next layer's operand loader.

## Interface
- N, 8, matrix dimension; the stream is N*N elements long
- SHIFT, 4, requantization right-shift amount, legal range 0..15
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- done_in  in  1  multiplier done level; a capture happens on its rising edge
- c_in  in  N*N*16  flattened signed result matrix; element (r,c) is at bits [(r*N+c)*16 +: 16]
- out_valid  out  1  element present on out_data
- out_ready  in  1  consumer accepts the element
- out_data  out  8  signed requantized element
- out_row, out_col  out  3 each  index of the current element
- out_last  out  1  high with element (N-1,N-1)
- busy  out  1  a capture is being streamed
- matrix_done  out  1  one-cycle pulse after the last element is accepted
- overrun  out  1  one-cycle pulse when a done_in rising edge arrives while busy
- sat_count  out  7  number of saturated elements in the current or most recent matrix

## Operation
- States: IDLE, STREAM.
- done_q registers done_in. A rise is `done_in & ~done_q`.
- IDLE + rise: latch c_in into the capture buffer, clear the index and sat_count, and go to STREAM.
- STREAM: present the element at the index. On a transfer (`out_valid & out_ready`):
  - advance col, with row wrap at N-1;
  - increment sat_count if the element saturated;
  - on the last element, go to IDLE and pulse matrix_done.
- Requantize:
  - Extend x to a 17-bit signed value.
  - If SHIFT>0, t = (x + 2^(SHIFT-1)) >>> SHIFT; otherwise t = x.
  - Clamp t to [-128,127]. The element counts as saturated if clamping changed the value.
- A rise while in STREAM is ignored: the buffer is untouched and overrun pulses.
- Rise coinciding with the last transfer: treated as occurring while busy, so it is ignored and overrun pulses.
- sat_count holds its value in IDLE until the next capture.

## Timing
- Reset values: out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0, matrix_done=0, overrun=0, sat_count=0, done_q=0, state=IDLE.
- Rise seen in cycle t: buffer captured at the edge ending t. out_valid=1 and busy=1 from cycle t+1 with element (0,0).
- out_data, out_row, out_col and out_last are driven from registers and stay stable while `out_valid & ~out_ready`. out_valid never drops without a transfer.
- With out_ready held high, the 64 elements take 64 consecutive cycles, t+1..t+64. matrix_done is high in t+65 with busy=0 and out_valid=0.
- Minimum gap from matrix_done to the next accepted capture: 0 cycles, because a rise in the matrix_done cycle is accepted.
- Reset asserted mid-stream aborts the stream. Next cycle all outputs are at reset values and the remaining elements are discarded.

## Configuration
- MATMUL_DRAIN_RELU_EN defined: after clamping, negative results become 0. Elements that are zeroed this way are not counted as saturated.
- Undefined: the full signed range [-128,127] is output.

## Structure
- matmul_pkg holds:
  - the N, ELEM_IN_W=16 and ELEM_OUT_W=8 constants;
  - the drain state enum;
  - the SAT_MAX=127 and SAT_MIN=-128 constants.
- The combinational sub-module requant8 takes x[15:0] and returns y[7:0] and a sat flag. It is instantiated once on the muxed buffer element.
- The top level holds the FSM, the index counters, the capture buffer and the edge detect.

## Test plan
- SHIFT=4, all C=256, out_ready=1 -> 64 elements of value 16. out_last on the 64th, matrix_done at t+65, sat_count=0.
- C(0,0)=32767, C(0,1)=-32768, C(0,2)=-24, C(0,3)=7, C(0,4)=8 -> 127, -128, -1, 0, 1. sat_count=2. With MATMUL_DRAIN_RELU_EN, C(0,1)=-32768 -> 0 and C(0,2)=-24 -> 0, sat_count=1.
- Random out_ready (50%) -> data, row and col stable during stalls. No element lost or duplicated, and the row-major order matches the model.
- done_in rises again mid-stream with a different C -> overrun pulses once and the streamed data is all from the first capture.
- done_in held high across two matrices without a fall -> only one capture is made.
- rst asserted at element 20 -> outputs zero next cycle. A new rise then streams from (0,0) with sat_count restarted.
